// File: rtl/instr_fetch_stage_pkg.sv
// Shared fetch definitions: parameter defaults, next-PC select encodings and the IF/ID record.
package instr_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam int          IMEM_AW_DEFAULT   = 10;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ   = 2'd0,
    NPC_REDIR = 2'd1,
    NPC_FLUSH = 2'd2,
    NPC_HOLD  = 2'd3
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } ifid_t;

  // Flush beats stall, stall beats redirect; a stalled redirect is re-issued by ID later.
  function automatic npc_sel_e npc_select(input logic flush, input logic stall,
                                          input logic redirect);
    if (flush)         return NPC_FLUSH;
    else if (stall)    return NPC_HOLD;
    else if (redirect) return NPC_REDIR;
    return NPC_SEQ;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: priority next-PC mux feeding an asynchronously reset PC register.
module fetch_pc_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc
);

  logic [31:0] next_pc;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    next_pc = pc;
    unique case (npc_sel_e'(npc_sel))
      NPC_SEQ:   next_pc = pc + 32'd4;
      NPC_REDIR: next_pc = redirect_pc;
      NPC_FLUSH: next_pc = flush_pc;
      NPC_HOLD:  next_pc = pc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and writes the IF/ID register.
// Optional macro FETCH_ADDR_CHECK_EN adds the id_fetch_fault output and the fetch range check.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          IMEM_AW   = IMEM_AW_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic [IMEM_AW-1:0] instr_addr,
  input  logic [31:0]        instr_data,
  output logic [31:0]        pc,
`ifdef FETCH_ADDR_CHECK_EN
  output logic               id_fetch_fault,
`endif
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc8,
  output logic               id_valid
);

  logic [1:0] npc_sel;
  logic       fetch_fault;
  ifid_t      ifid_q, ifid_d;

  assign npc_sel = npc_select(flush, stall, redirect);

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .npc_sel    (npc_sel),
    .redirect_pc(redirect_pc),
    .flush_pc   (flush_pc),
    .pc         (pc)
  );

  // Upper PC bits are dropped, so the memory aliases every 4*2^IMEM_AW bytes.
  assign instr_addr = pc[IMEM_AW+1:2];

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'd1 << (IMEM_AW + 2));
  logic fault_q, fault_d;

  assign fetch_fault = (pc[1:0] != 2'b00) || (pc < RESET_PC) || ({1'b0, pc} >= PC_LIMIT);
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    ifid_d = ifid_q;
    unique case (npc_sel_e'(npc_sel))
      NPC_FLUSH: ifid_d = '{instr: NOP_INSTR, pc: 32'd0, pc8: 32'd0, valid: 1'b0};
      NPC_HOLD:  ifid_d = ifid_q;
      default: begin
        // A faulting fetch still records its pc so the handler can report it.
        if (fetch_fault) ifid_d = '{instr: NOP_INSTR, pc: pc, pc8: pc + 32'd8, valid: 1'b0};
        else             ifid_d = '{instr: instr_data, pc: pc, pc8: pc + 32'd8, valid: 1'b1};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ifid_q <= '{instr: NOP_INSTR, pc: 32'd0, pc8: 32'd0, valid: 1'b0};
    else       ifid_q <= ifid_d;
  end

`ifdef FETCH_ADDR_CHECK_EN
  always_comb begin
    fault_d = fault_q;
    unique case (npc_sel_e'(npc_sel))
      NPC_FLUSH: fault_d = 1'b0;
      NPC_HOLD:  fault_d = fault_q;
      default:   fault_d = fetch_fault;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign id_fetch_fault = fault_q;
`endif

  assign id_instr = ifid_q.instr;
  assign id_pc    = ifid_q.pc;
  assign id_pc8   = ifid_q.pc8;
  assign id_valid = ifid_q.valid;

endmodule
